// File: rtl/pattern_uart_loader.sv
// Purpose: UART 8N1 receiver plus frame parser feeding pattern_manager with {timestamp, pattern} words.
// Latency: word and write strobe appear on the clock edge after the final byte's mid-stop-bit sample.
// Backpressure: none; write is a bare strobe, so the host must pace frames no faster than the consumer takes them.
//
// Ports:
//   CLOCK50M, RESET_N        - system clock, asynchronous active-low reset
//   uart_rx                  - asynchronous serial input, idle high
//   pattern_with_timestamp   - last accepted word {ts[9:0], pattern[7:0]}
//   write                    - one-cycle strobe when pattern_with_timestamp is updated
//   frame_count, error_count - saturating accepted / rejected frame counters
//   rx_busy                  - parser is inside a frame
// Build option: define PATTERN_LOADER_CHECKSUM_EN for 5-byte frames with an XOR checksum byte;
// without it frames are 4 bytes (sync, ts_hi, ts_lo, pattern) and are accepted after the pattern byte.

module pattern_uart_loader #(
  parameter int         CLKS_PER_BIT   = 434,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        CLOCK50M,
  input  logic        RESET_N,
  input  logic        uart_rx,
  output logic [17:0] pattern_with_timestamp,
  output logic        write,
  output logic [7:0]  frame_count,
  output logic [7:0]  error_count,
  output logic        rx_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------- synchronizer
  // rx_prev is one more stage so a falling edge can be seen on synchronized data.
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge CLOCK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------- byte receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state, rx_next;
  logic [11:0] bit_clk;
  logic [2:0]  bit_idx;
  logic [7:0]  rx_shift;
  logic        half_tick, full_tick;
  logic        byte_valid, framing_err;

  assign half_tick = (bit_clk == 12'(HALF_BIT - 1));
  assign full_tick = (bit_clk == 12'(CLKS_PER_BIT - 1));

  always_comb begin
    rx_next     = rx_state;
    byte_valid  = 1'b0;
    framing_err = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      // A start bit that is high again at mid-bit was a glitch.
      RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_tick && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (full_tick) begin
          rx_next     = RX_IDLE;
          byte_valid  = rx_sync;
          framing_err = !rx_sync;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_state <= RX_IDLE;
      bit_clk  <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      // Bit timer restarts on every state change and at each data-bit boundary,
      // so after the half-bit start sample every later sample lands mid-bit.
      if (rx_state == RX_IDLE || rx_state != rx_next || (rx_state == RX_DATA && full_tick))
        bit_clk <= '0;
      else
        bit_clk <= bit_clk + 12'd1;
      if (rx_state == RX_START)
        bit_idx <= '0;
      else if (rx_state == RX_DATA && full_tick)
        bit_idx <= bit_idx + 3'd1;
      if (rx_state == RX_DATA && full_tick)
        rx_shift <= {rx_sync, rx_shift[7:1]};   // LSB first
    end
  end

  // ---------------------------------------------------------------- frame parser
  typedef enum logic [2:0] {HUNT, TS_HI, TS_LO, PAT, CHK} parse_state_t;

  parse_state_t      p_state, p_next;
  logic [1:0]        ts_hi_q;
  logic [7:0]        ts_lo_q;
`ifdef PATTERN_LOADER_CHECKSUM_EN
  logic [7:0]        pat_q;
`endif
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_hit, accept, frame_err;
  logic [17:0]       accept_word;

  // A byte arriving on the timeout cycle takes priority, so the timeout is masked.
  assign timeout_hit = (p_state != HUNT) && !byte_valid &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    p_next      = p_state;
    accept      = 1'b0;
    frame_err   = 1'b0;
`ifdef PATTERN_LOADER_CHECKSUM_EN
    accept_word = {ts_hi_q, ts_lo_q, pat_q};
`else
    accept_word = {ts_hi_q, ts_lo_q, rx_shift};
`endif
    if (byte_valid) begin
      case (p_state)
        HUNT:  if (rx_shift == SYNC_BYTE) p_next = TS_HI;
        TS_HI: begin
          if (|rx_shift[7:2]) begin
            frame_err = 1'b1;
            p_next    = HUNT;
          end else begin
            p_next = TS_LO;
          end
        end
        TS_LO: p_next = PAT;
`ifdef PATTERN_LOADER_CHECKSUM_EN
        PAT:   p_next = CHK;
        CHK: begin
          p_next = HUNT;
          if (rx_shift == ({6'b0, ts_hi_q} ^ ts_lo_q ^ pat_q)) accept = 1'b1;
          else                                                 frame_err = 1'b1;
        end
`else
        PAT: begin
          p_next = HUNT;
          accept = 1'b1;
        end
`endif
        default: p_next = HUNT;
      endcase
    end else if ((framing_err && p_state != HUNT) || timeout_hit) begin
      frame_err = 1'b1;
      p_next    = HUNT;
    end
  end

  always_ff @(posedge CLOCK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      p_state                <= HUNT;
      ts_hi_q                <= '0;
      ts_lo_q                <= '0;
`ifdef PATTERN_LOADER_CHECKSUM_EN
      pat_q                  <= '0;
`endif
      idle_cnt               <= '0;
      pattern_with_timestamp <= '0;
      write                  <= 1'b0;
      frame_count            <= '0;
      error_count            <= '0;
    end else begin
      p_state <= p_next;
      if (byte_valid && p_state == TS_HI) ts_hi_q <= rx_shift[1:0];
      if (byte_valid && p_state == TS_LO) ts_lo_q <= rx_shift;
`ifdef PATTERN_LOADER_CHECKSUM_EN
      if (byte_valid && p_state == PAT)   pat_q   <= rx_shift;
`endif
      if (byte_valid || p_state == HUNT) idle_cnt <= '0;
      else                               idle_cnt <= idle_cnt + 1'b1;
      write <= accept;
      if (accept) begin
        pattern_with_timestamp <= accept_word;
        if (frame_count != 8'hFF) frame_count <= frame_count + 8'd1;
      end
      if (frame_err && error_count != 8'hFF) error_count <= error_count + 8'd1;
    end
  end

  assign rx_busy = (p_state != HUNT);

endmodule
